ex1_stage: RTL and testbench
============================

Name: ex1_stage

Overview:
- Execute-1 stage. Consumes the ID/EX register outputs and registers its results into the EX1/EX2 boundary.
- Contains: operand forwarding from EX2 and WB, ALU, branch resolution, and an iterative 16-cycle multiplier that stalls the front of the pipe.
- Sits between the ID/EX register and the EX2/MEM stage. Drives the global stall and branch-redirect signals.

Parameters:
- DW, 16, datapath width
- RW, 4, register index width (16 registers; r0 reads as zero)
- MUL_CYCLES, 16, iteration count of the shift-add multiplier (must equal DW)

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- ex_pc, ex_rs1_data, ex_rs2_data, ex_imm  in  16 each  from ID/EX register
- ex_rs1, ex_rs2, ex_rd  in  4 each  register indices
- ex_alu_op  in  4  operation select
- ex_reg_write, ex_alu_src, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_branch, ex_branch_ne  in  1 each  controls
- fw_mem_rd  in  4, fw_mem_reg_write  in  1, fw_mem_data  in  16  EX2 result for forwarding
- fw_wb_rd  in  4, fw_wb_reg_write  in  1, fw_wb_data  in  16  writeback result for forwarding
- stall  out  1  holds PC, IF/ID and ID/EX (combinational)
- branch_taken  out  1  redirect request (combinational)
- branch_target  out  16  ex_pc + ex_imm, modulo 2^16 (combinational)
- ex2_result, ex2_store_data  out  16 each  registered ALU/MUL result; forwarded rs2
- ex2_rd  out  4  registered destination index
- ex2_reg_write, ex2_mem_read, ex2_mem_write, ex2_mem_to_reg  out  1 each  registered controls

Behaviour:
- Reset:
  - All ex2_* outputs are 0 and the FSM is IDLE with iteration counter 0, so stall=0.
  - branch_taken follows its inputs: 0 while the ID/EX register is in reset.
- Forwarding (per operand, index r):
  - r==0 gives 0.
  - Else fw_mem_reg_write && fw_mem_rd==r gives fw_mem_data (EX2 has priority).
  - Else fw_wb_reg_write && fw_wb_rd==r gives fw_wb_data.
  - Else the register-file value.
  - Yields op_a = fwd rs1 and fwd_b = fwd rs2; op_b = ex_alu_src ? ex_imm : fwd_b.
- ALU, single cycle, 16-bit wrap:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR.
  - 5 SLL, 6 SRL, 7 SRA; shift amount is op_b[3:0].
  - 8 SLT (signed, result 1/0).
  - 9 MUL (low 16 bits, multi-cycle).
  - 10-15 reserved, result 0.
- Branch: branch_taken = (ex_branch && op_a==fwd_b) || (ex_branch_ne && op_a!=fwd_b). Forced 0 while FSM is not IDLE.
- Normal op (FSM IDLE, alu_op!=9): at each posedge, ex2_* captures the result, fwd_b and ex_rd plus controls. Latency is 1 cycle.
- MUL FSM: IDLE -> BUSY -> DONE -> IDLE.
  - IDLE, op 9 present:
    - stall=1.
    - Latch op_a (multiplicand), op_b (multiplier), rd and controls.
    - Clear the accumulator; counter=MUL_CYCLES-1.
    - Go to BUSY.
    - Inject a bubble into ex2_* (all controls 0, data 0).
  - BUSY:
    - stall=1; ex2_* receives a bubble each cycle.
    - Each cycle: if multiplier[0], acc += multiplicand; multiplicand <<= 1; multiplier >>= 1; counter--.
    - When counter==0 on a BUSY cycle, go to DONE.
  - DONE:
    - stall=0.
    - At the next posedge, ex2_* captures acc with the latched rd/controls. The ID/EX register advances on the same edge.
    - Go to IDLE.
  - Total: stall high for exactly 17 consecutive cycles per MUL; the result reaches ex2_result 18 edges after the MUL entered EX1.
  - Operands are latched at entry. Forwarding changes during BUSY have no effect.
  - The acc overflow above 16 bits is discarded.
- Back-to-back MUL: the second MUL enters at DONE->IDLE and starts a fresh 17-cycle stall with no overlap.
- Reset mid-multiply: immediate return to IDLE, stall drops asynchronously, ex2_* cleared, and the partial product is discarded.

Optional Feature:
- EX1_MUL_EN.
  - Defined: iterative multiplier and FSM as above.
  - Undefined: op 9 behaves as reserved (result 0, single cycle). The FSM, accumulator and counter are not built, stall is tied 0, and the branch gate is always open.

Test Plan:
- ADD r3=r1+r2, rs1 data 0x0005 stale; fw_mem_rd=1 with write=1, data 0x0010; rs2=0x0003 -> ex2_result=0x0013 one edge later.
- fw_mem and fw_wb both target r2 (mem 0x1111, wb 0x2222) -> mem value used. Both target r0 -> operand 0, no forwarding.
- MUL 300*200 -> stall high 17 cycles, bubbles on ex2_*, then ex2_result=0xEA60 with ex2_reg_write=1. MUL 0xFFFF*0xFFFF -> 0x0001.
- BNE with op_a=0x0004, fwd_b=0x0005, ex_pc=0x0020, ex_imm=0xFFF0 -> branch_taken=1, branch_target=0x0010. Equal operands -> taken=0.
- Assert rst during BUSY cycle 7 -> stall=0 and ex2_* all 0 immediately. After release, an ADD completes normally in 1 cycle.
- Build without EX1_MUL_EN, alu_op=9 -> ex2_result=0, stall never asserts.

Source files
------------

// File: rtl/ex1_stage.sv
// ex1_stage: execute-1 with forwarding, ALU, branch resolve and optional iterative multiplier (EX1_MUL_EN)
module ex1_stage #(
  parameter int DW = 16,
  parameter int RW = 4,
  parameter int MUL_CYCLES = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] ex_pc,
  input  logic [DW-1:0] ex_rs1_data,
  input  logic [DW-1:0] ex_rs2_data,
  input  logic [DW-1:0] ex_imm,
  input  logic [RW-1:0] ex_rs1,
  input  logic [RW-1:0] ex_rs2,
  input  logic [RW-1:0] ex_rd,
  input  logic [3:0]    ex_alu_op,
  input  logic          ex_reg_write,
  input  logic          ex_alu_src,
  input  logic          ex_mem_read,
  input  logic          ex_mem_write,
  input  logic          ex_mem_to_reg,
  input  logic          ex_branch,
  input  logic          ex_branch_ne,
  input  logic [RW-1:0] fw_mem_rd,
  input  logic          fw_mem_reg_write,
  input  logic [DW-1:0] fw_mem_data,
  input  logic [RW-1:0] fw_wb_rd,
  input  logic          fw_wb_reg_write,
  input  logic [DW-1:0] fw_wb_data,
  output logic          stall,
  output logic          branch_taken,
  output logic [DW-1:0] branch_target,
  output logic [DW-1:0] ex2_result,
  output logic [DW-1:0] ex2_store_data,
  output logic [RW-1:0] ex2_rd,
  output logic          ex2_reg_write,
  output logic          ex2_mem_read,
  output logic          ex2_mem_write,
  output logic          ex2_mem_to_reg
);
  localparam logic [3:0] OP_MUL = 4'd9;
  logic [DW-1:0] w_op_a, w_fwd_b, w_op_b, w_alu, w_mul_res;
  logic [RW-1:0] w_mul_rd;
  logic [3:0]    w_mul_ctl;
  logic          w_done, w_br_en;
  // operand forwarding, EX2 result wins over writeback, r0 is hard zero
  always_comb begin
    w_op_a  = ex_rs1 == '0 ? '0 :
              (fw_mem_reg_write && fw_mem_rd == ex_rs1) ? fw_mem_data :
              (fw_wb_reg_write && fw_wb_rd == ex_rs1) ? fw_wb_data : ex_rs1_data;
    w_fwd_b = ex_rs2 == '0 ? '0 :
              (fw_mem_reg_write && fw_mem_rd == ex_rs2) ? fw_mem_data :
              (fw_wb_reg_write && fw_wb_rd == ex_rs2) ? fw_wb_data : ex_rs2_data;
    w_op_b  = ex_alu_src ? ex_imm : w_fwd_b;
  end
  // single-cycle ALU; MUL and reserved codes yield 0 here
  always_comb begin
    w_alu = '0;
    case (ex_alu_op)
      4'd0:    w_alu = w_op_a + w_op_b;
      4'd1:    w_alu = w_op_a - w_op_b;
      4'd2:    w_alu = w_op_a & w_op_b;
      4'd3:    w_alu = w_op_a | w_op_b;
      4'd4:    w_alu = w_op_a ^ w_op_b;
      4'd5:    w_alu = w_op_a << w_op_b[3:0];
      4'd6:    w_alu = w_op_a >> w_op_b[3:0];
      4'd7:    w_alu = $unsigned($signed(w_op_a) >>> w_op_b[3:0]);
      4'd8:    w_alu = {{(DW-1){1'b0}}, $signed(w_op_a) < $signed(w_op_b)};
      default: w_alu = '0;
    endcase
  end
  assign branch_target = ex_pc + ex_imm;
  assign branch_taken  = w_br_en && ((ex_branch && w_op_a == w_fwd_b) || (ex_branch_ne && w_op_a != w_fwd_b));
`ifdef EX1_MUL_EN
  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;
  localparam int CW = $clog2(MUL_CYCLES);
  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [DW-1:0] r_acc, r_mcand, r_mplier;
  logic [RW-1:0] r_m_rd;
  logic [3:0]    r_m_ctl;
  logic          w_start;
  assign w_start   = ex_alu_op == OP_MUL;
  assign w_mul_res = r_acc;
  assign w_mul_rd  = r_m_rd;
  assign w_mul_ctl = r_m_ctl;
  // multiplier state register
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  // next state: one entry cycle, MUL_CYCLES busy cycles, one result cycle
  always_comb
    w_state_nxt = r_state == S_IDLE ? (w_start ? S_BUSY : S_IDLE) :
                  r_state == S_BUSY ? (r_cnt == '0 ? S_DONE : S_BUSY) : S_IDLE;
  // stall front of pipe while multiplying; branches are ignored outside IDLE
  always_comb begin
    stall   = r_state == S_BUSY || (r_state == S_IDLE && w_start);
    w_done  = r_state == S_DONE;
    w_br_en = r_state == S_IDLE;
  end
  // shift-add datapath; operands and destination frozen at entry
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_cnt    <= '0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_m_rd   <= '0;
      r_m_ctl  <= '0;
    end else if (r_state == S_IDLE && w_start) begin
      r_cnt    <= CW'(MUL_CYCLES - 1);
      r_acc    <= '0;
      r_mcand  <= w_op_a;
      r_mplier <= w_op_b;
      r_m_rd   <= ex_rd;
      r_m_ctl  <= {ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg};
    end else if (r_state == S_BUSY) begin
      r_acc    <= r_mplier[0] ? r_acc + r_mcand : r_acc;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt - 1'b1;
    end
`else
  assign stall     = 1'b0;
  assign w_done    = 1'b0;
  assign w_br_en   = 1'b1;
  assign w_mul_res = '0;
  assign w_mul_rd  = '0;
  assign w_mul_ctl = '0;
`endif
  // EX1/EX2 boundary: multiply result, bubble while stalled, else ALU result
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      ex2_result     <= '0;
      ex2_store_data <= '0;
      ex2_rd         <= '0;
      {ex2_reg_write, ex2_mem_read, ex2_mem_write, ex2_mem_to_reg} <= '0;
    end else if (w_done) begin
      ex2_result     <= w_mul_res;
      ex2_store_data <= '0;
      ex2_rd         <= w_mul_rd;
      {ex2_reg_write, ex2_mem_read, ex2_mem_write, ex2_mem_to_reg} <= w_mul_ctl;
    end else if (stall) begin
      ex2_result     <= '0;
      ex2_store_data <= '0;
      ex2_rd         <= '0;
      {ex2_reg_write, ex2_mem_read, ex2_mem_write, ex2_mem_to_reg} <= '0;
    end else begin
      ex2_result     <= w_alu;
      ex2_store_data <= w_fwd_b;
      ex2_rd         <= ex_rd;
      {ex2_reg_write, ex2_mem_read, ex2_mem_write, ex2_mem_to_reg} <= {ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg};
    end
endmodule

// File: tb/tb_ex1_stage.sv
// tb_ex1_stage: directed self-checking bench for ex1_stage
module tb_ex1_stage;
  logic        clk = 0, rst;
  logic [15:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, fw_mem_data, fw_wb_data;
  logic [3:0]  ex_rs1, ex_rs2, ex_rd, ex_alu_op, fw_mem_rd, fw_wb_rd;
  logic        ex_reg_write, ex_alu_src, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_branch, ex_branch_ne;
  logic        fw_mem_reg_write, fw_wb_reg_write;
  logic        stall, branch_taken;
  logic [15:0] branch_target, ex2_result, ex2_store_data;
  logic [3:0]  ex2_rd;
  logic        ex2_reg_write, ex2_mem_read, ex2_mem_write, ex2_mem_to_reg;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  ex1_stage dut (
    .clk(clk), .rst(rst), .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_alu_op(ex_alu_op), .ex_reg_write(ex_reg_write),
    .ex_alu_src(ex_alu_src), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg),
    .ex_branch(ex_branch), .ex_branch_ne(ex_branch_ne), .fw_mem_rd(fw_mem_rd), .fw_mem_reg_write(fw_mem_reg_write),
    .fw_mem_data(fw_mem_data), .fw_wb_rd(fw_wb_rd), .fw_wb_reg_write(fw_wb_reg_write), .fw_wb_data(fw_wb_data),
    .stall(stall), .branch_taken(branch_taken), .branch_target(branch_target), .ex2_result(ex2_result),
    .ex2_store_data(ex2_store_data), .ex2_rd(ex2_rd), .ex2_reg_write(ex2_reg_write), .ex2_mem_read(ex2_mem_read),
    .ex2_mem_write(ex2_mem_write), .ex2_mem_to_reg(ex2_mem_to_reg)
  );
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic drv(input logic [3:0] op, input logic [3:0] rs1, input logic [15:0] d1, input logic [3:0] rs2,
                     input logic [15:0] d2, input logic [3:0] rd, input logic src, input logic [15:0] imm);
    ex_alu_op = op; ex_rs1 = rs1; ex_rs1_data = d1; ex_rs2 = rs2; ex_rs2_data = d2; ex_rd = rd;
    ex_alu_src = src; ex_imm = imm; ex_reg_write = 1; ex_mem_read = 0; ex_mem_write = 0; ex_mem_to_reg = 0;
    ex_branch = 0; ex_branch_ne = 0; ex_pc = 0;
    fw_mem_rd = 0; fw_mem_reg_write = 0; fw_mem_data = 0; fw_wb_rd = 0; fw_wb_reg_write = 0; fw_wb_data = 0;
  endtask
  logic [3:0]  t_op  [9] = '{4'd5, 4'd6, 4'd7, 4'd8, 4'd8, 4'd2, 4'd4, 4'd0, 4'd12};
  logic [15:0] t_a   [9] = '{16'h0001, 16'h8000, 16'h8000, 16'hFFFF, 16'h0001, 16'hF0F0, 16'hF0F0, 16'hFFFF, 16'h0005};
  logic [15:0] t_imm [9] = '{16'h001F, 16'h0004, 16'h0004, 16'h0001, 16'hFFFF, 16'hFF00, 16'hFF00, 16'h0002, 16'h0006};
  logic [15:0] t_exp [9] = '{16'h8000, 16'h0800, 16'hF800, 16'h0001, 16'h0000, 16'hF000, 16'h0FF0, 16'h0001, 16'h0000};
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end
  initial begin
    int n;
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    ex_reg_write = 0;
    rst = 1;
    step; step;
    chk("rst_result", ex2_result, 0);
    chk("rst_rd", ex2_rd, 0);
    chk("rst_rw", ex2_reg_write, 0);
    chk("rst_stall", stall, 0);
    chk("rst_br", branch_taken, 0);
    rst = 0;
    drv(0, 1, 16'h0005, 2, 16'h0003, 3, 0, 0);
    fw_mem_rd = 1; fw_mem_reg_write = 1; fw_mem_data = 16'h0010;
    step;
    chk("add_fwd_mem", ex2_result, 16'h0013);
    chk("add_rd", ex2_rd, 3);
    chk("add_rw", ex2_reg_write, 1);
    chk("add_store", ex2_store_data, 16'h0003);
    drv(0, 0, 16'h7777, 2, 16'h0003, 4, 0, 0);
    fw_mem_rd = 2; fw_mem_reg_write = 1; fw_mem_data = 16'h1111;
    fw_wb_rd = 2; fw_wb_reg_write = 1; fw_wb_data = 16'h2222;
    step;
    chk("prio_result", ex2_result, 16'h1111);
    chk("prio_store", ex2_store_data, 16'h1111);
    drv(3, 0, 16'h0005, 0, 16'h0006, 5, 0, 0);
    fw_mem_rd = 0; fw_mem_reg_write = 1; fw_mem_data = 16'h1111;
    fw_wb_rd = 0; fw_wb_reg_write = 1; fw_wb_data = 16'h2222;
    step;
    chk("r0_result", ex2_result, 0);
    chk("r0_store", ex2_store_data, 0);
    drv(1, 1, 16'h0000, 2, 16'h0005, 6, 0, 0);
    fw_wb_rd = 1; fw_wb_reg_write = 1; fw_wb_data = 16'h0003;
    step;
    chk("sub_fwd_wb", ex2_result, 16'hFFFE);
    for (int i = 0; i < 9; i++) begin
      drv(t_op[i], 1, t_a[i], 2, 16'hABCD, 7, 1, t_imm[i]);
      step;
      chk($sformatf("alu_%0d", i), ex2_result, t_exp[i]);
    end
    chk("imm_store", ex2_store_data, 16'hABCD);
    drv(0, 1, 16'h0004, 2, 16'h0005, 0, 0, 16'hFFF0);
    ex_reg_write = 0; ex_pc = 16'h0020; ex_branch_ne = 1;
    #1;
    chk("bne_taken", branch_taken, 1);
    chk("bne_target", branch_target, 16'h0010);
    ex_rs2_data = 16'h0004;
    #1;
    chk("bne_equal", branch_taken, 0);
    ex_branch_ne = 0; ex_branch = 1;
    #1;
    chk("beq_equal", branch_taken, 1);
    step;
`ifdef EX1_MUL_EN
    drv(9, 1, 16'd300, 2, 16'd200, 7, 0, 0);
    #1;
    chk("mul_stall0", stall, 1);
    n = 0;
    while (stall && n < 40) begin
      step;
      n++;
      if (n == 5) chk("mul_bubble", {15'd0, ex2_reg_write, ex2_result}, 0);
    end
    chk("mul_stall_len", n, 17);
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    step;
    chk("mul_result", ex2_result, 16'hEA60);
    chk("mul_rw", ex2_reg_write, 1);
    chk("mul_rd", ex2_rd, 7);
    chk("mul_after_stall", stall, 0);
    drv(9, 1, 16'hFFFF, 2, 16'hFFFF, 8, 0, 0);
    #1;
    n = 0;
    while (stall && n < 40) begin
      step;
      n++;
    end
    chk("mul2_stall_len", n, 17);
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    step;
    chk("mul2_result", ex2_result, 16'h0001);
    drv(9, 1, 16'd300, 2, 16'd200, 7, 0, 0);
    repeat (7) step;
    chk("mid_stall_before", stall, 1);
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    ex_reg_write = 0;
    rst = 1;
    #1;
    chk("mid_rst_stall", stall, 0);
    chk("mid_rst_ex2", {ex2_result, ex2_rd, ex2_reg_write, ex2_mem_read, ex2_mem_write, ex2_mem_to_reg}, 0);
    step;
    rst = 0;
    drv(0, 1, 16'h0002, 2, 16'h0003, 9, 0, 0);
    #1;
    chk("post_rst_stall", stall, 0);
    step;
    chk("post_rst_add", ex2_result, 16'h0005);
    chk("post_rst_rd", ex2_rd, 9);
`else
    drv(9, 1, 16'd300, 2, 16'd200, 7, 0, 0);
    #1;
    chk("nomul_stall", stall, 0);
    step;
    chk("nomul_result", ex2_result, 0);
    chk("nomul_rw", ex2_reg_write, 1);
    chk("nomul_stall_after", stall, 0);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
